// File: rtl/seq_num_alloc_arb.sv
// Round-robin arbiter that shares the sequence-number generator's single allocation
// port among p_num_reqs requesters. A requester can lock the port for a contiguous burst.
module seq_num_alloc_arb #(
    parameter int p_seq_num_bits = 5,
    parameter int p_num_reqs     = 2,
    parameter int p_max_burst    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [p_seq_num_bits-1:0]     gen_alloc_seq_num,
    input  logic                          gen_alloc_val,
    output logic                          gen_alloc_rdy,
    input  logic [p_num_reqs-1:0]         req_val,
    input  logic [p_num_reqs-1:0]         req_lock,
    output logic [p_num_reqs-1:0]         req_rdy,
    output logic [p_seq_num_bits-1:0]     req_seq_num,
    input  logic                          squash_val,
    output logic [$clog2(p_num_reqs)-1:0] grant_id,
    output logic                          locked
);

    localparam int IW = $clog2(p_num_reqs);
    localparam int BW = $clog2(p_max_burst + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q;
    logic [IW-1:0] prio_q;
    logic [IW-1:0] owner_q;
    logic [BW-1:0] burst_q;

    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic          xfer;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] id);
        return (id == IW'(p_num_reqs - 1)) ? '0 : id + 1'b1;
    endfunction

    // Candidate selection: owner only while locked, else a cyclic search from prio_q.
    // Iterating the offset downwards leaves the nearest requester as the winner.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state_q == LOCKED) begin
            if (req_val[owner_q]) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end
        end else begin
            for (int k = p_num_reqs - 1; k >= 0; k--) begin
                idx = int'(prio_q) + k;
                if (idx >= p_num_reqs) idx = idx - p_num_reqs;
                if (req_val[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IW'(idx);
                end
            end
        end
    end

    // rst_n gates the handshake so the grant drops the instant reset is asserted.
    assign xfer = gnt_any && gen_alloc_val && !squash_val && rst_n;

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < p_num_reqs; i++)
            req_rdy[i] = xfer && (gnt_idx == IW'(i));
    end

    assign gen_alloc_rdy = xfer;
    assign req_seq_num   = gen_alloc_seq_num;
    assign locked        = (state_q == LOCKED);

    always_comb begin
        if (xfer)                  grant_id = gnt_idx;
        else if (state_q == LOCKED) grant_id = owner_q;
        else                       grant_id = prio_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= '0;
            owner_q <= '0;
            burst_q <= '0;
        end else if (squash_val) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (req_lock[gnt_idx] && (p_max_burst > 1)) begin
                            state_q <= LOCKED;
                            owner_q <= gnt_idx;
                            burst_q <= BW'(1);
                        end else begin
                            prio_q <= wrap_inc(gnt_idx);
                        end
                    end
                end
                LOCKED: begin
                    // A lock release and a final transfer share the same exit path.
                    if (!req_lock[owner_q] || (xfer && (burst_q + 1'b1 == BW'(p_max_burst)))) begin
                        state_q <= IDLE;
                        prio_q  <= wrap_inc(owner_q);
                        burst_q <= '0;
                    end else if (xfer) begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_num_alloc_arb.sv
// Directed bench for seq_num_alloc_arb: a 2-requester/4-burst instance and a
// 3-requester instance with locking disabled (p_max_burst=1).
module tb_seq_num_alloc_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] gen_seq;
    logic       gen_val;
    logic       squash;

    logic       gen_rdy;
    logic [1:0] req_val, req_lock, req_rdy;
    logic [4:0] req_seq;
    logic       grant_id;
    logic       locked;

    logic       gen_rdy3;
    logic [2:0] req_val3, req_lock3, req_rdy3;
    logic [4:0] req_seq3;
    logic [1:0] grant_id3;
    logic       locked3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_num_alloc_arb #(.p_seq_num_bits(5), .p_num_reqs(2), .p_max_burst(4)) dut (
        .clk(clk), .rst_n(rst_n), .gen_alloc_seq_num(gen_seq), .gen_alloc_val(gen_val),
        .gen_alloc_rdy(gen_rdy), .req_val(req_val), .req_lock(req_lock), .req_rdy(req_rdy),
        .req_seq_num(req_seq), .squash_val(squash), .grant_id(grant_id), .locked(locked)
    );

    seq_num_alloc_arb #(.p_seq_num_bits(5), .p_num_reqs(3), .p_max_burst(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .gen_alloc_seq_num(gen_seq), .gen_alloc_val(gen_val),
        .gen_alloc_rdy(gen_rdy3), .req_val(req_val3), .req_lock(req_lock3), .req_rdy(req_rdy3),
        .req_seq_num(req_seq3), .squash_val(squash), .grant_id(grant_id3), .locked(locked3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tables, hand-derived.
    logic [1:0] t1_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic       t1_gid [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       t2_lck [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] t5_rdy [5] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] t5_gid [5] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        rst_n = 1'b0; gen_seq = '0; gen_val = 1'b1; squash = 1'b0;
        req_val = 2'b11; req_lock = 2'b00; req_val3 = '0; req_lock3 = '0;
        #3;
        chk("rst_rdy", req_rdy, 0);
        chk("rst_gen_rdy", gen_rdy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_gid", grant_id, 0);
        tick();
        rst_n = 1'b1;

        // plain round robin alternates between the two requesters
        for (int c = 0; c < 4; c++) begin
            gen_seq = 5'(c);
            #2;
            chk("t1_rdy", req_rdy, t1_rdy[c]);
            chk("t1_gid", grant_id, t1_gid[c]);
            chk("t1_seq", req_seq, c);
            chk("t1_gen_rdy", gen_rdy, 1);
            tick();
        end

        // burst of four to requester 0, then requester 1
        req_lock = 2'b01;
        for (int c = 0; c < 4; c++) begin
            gen_seq = 5'(c);
            #2;
            chk("t2_rdy", req_rdy, 2'b01);
            chk("t2_locked", locked, t2_lck[c]);
            tick();
        end
        #2;
        chk("t2_after_locked", locked, 0);
        chk("t2_after_rdy", req_rdy, 2'b10);
        chk("t2_after_gid", grant_id, 1);
        tick();

        // owner stalls while locked; others are blocked
        #2;
        chk("t3_enter_rdy", req_rdy, 2'b01);
        tick();
        req_val = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("t3_stall_rdy", req_rdy, 0);
            chk("t3_stall_gen_rdy", gen_rdy, 0);
            chk("t3_stall_locked", locked, 1);
            chk("t3_stall_gid", grant_id, 0);
            tick();
        end
        req_lock = 2'b00;
        #2;
        chk("t3_release_rdy", req_rdy, 0);
        tick();
        #2;
        chk("t3_next_rdy", req_rdy, 2'b10);
        chk("t3_next_locked", locked, 0);
        tick();

        // squash in the middle of a burst
        req_val = 2'b11; req_lock = 2'b01;
        #2; chk("t4_grant0", req_rdy, 2'b01); tick();
        #2; chk("t4_grant1", req_rdy, 2'b01); chk("t4_locked", locked, 1); tick();
        squash = 1'b1;
        #2;
        chk("t4_sq_rdy", req_rdy, 0);
        chk("t4_sq_gen_rdy", gen_rdy, 0);
        tick();
        squash = 1'b0; req_lock = 2'b00;
        #2;
        chk("t4_post_locked", locked, 0);
        chk("t4_post_rdy", req_rdy, 2'b01);
        tick();

        // no generator number: no grant, pointer held
        gen_val = 1'b0;
        #2;
        chk("t5_noval_rdy", req_rdy, 0);
        chk("t5_noval_gid", grant_id, 1);
        tick();
        gen_val = 1'b1;
        #2;
        chk("t5_resume_rdy", req_rdy, 2'b10);
        tick();

        // three requesters with locking disabled; 2 -> 0 wrap
        req_val = 2'b00; req_lock3 = 3'b111;
        req_val3 = 3'b100;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) req_val3 = 3'b111;
            #2;
            chk("t6_rdy", req_rdy3, t5_rdy[c]);
            chk("t6_gid", grant_id3, t5_gid[c]);
            chk("t6_locked", locked3, 0);
            tick();
        end
        req_val3 = '0; req_lock3 = '0;

        // asynchronous reset in the middle of a burst
        req_val = 2'b11; req_lock = 2'b01;
        #2; chk("t7_grant", req_rdy, 2'b01); tick();
        #2; chk("t7_locked", locked, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_rdy", req_rdy, 0);
        chk("t7_rst_gen_rdy", gen_rdy, 0);
        chk("t7_rst_locked", locked, 0);
        tick();
        req_val = 2'b11; req_lock = 2'b00;
        rst_n = 1'b1;
        #2;
        chk("t7_post_rdy", req_rdy, 2'b01);
        chk("t7_post_gid", grant_id, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_num_alloc_arb.md
Name: seq_num_alloc_arb

Overview:
- Round-robin arbiter that shares the single sequence-number allocation port of the fetch-side sequence number generator among p_num_reqs requesters (e.g. fetch lanes or threads).
- A requester may lock the port for a burst of consecutive sequence numbers, up to p_max_burst, so that a fetch bundle receives contiguous numbers.
- Grants are suppressed on squash cycles, and any held lock is released.
- Sits between the fetch requesters and the generator's alloc_val/alloc_rdy/alloc_seq_num handshake.

Parameters:
- p_seq_num_bits, 5, width of a sequence number
- p_num_reqs, 2, number of requesters (>=2)
- p_max_burst, 4, maximum transfers per lock (>=1; 1 disables locking)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- gen_alloc_seq_num  input  p_seq_num_bits  sequence number offered by the generator
- gen_alloc_val  input  1  generator has a number available
- gen_alloc_rdy  output  1  number consumed this cycle
- req_val  input  p_num_reqs  requester i wants a number
- req_lock  input  p_num_reqs  requester i requests/holds a burst lock
- req_rdy  output  p_num_reqs  one-hot; requester i receives gen_alloc_seq_num this cycle
- req_seq_num  output  p_seq_num_bits  broadcast of gen_alloc_seq_num
- squash_val  input  1  squash notification valid
- grant_id  output  $clog2(p_num_reqs)  index of current grant (valid when |req_rdy)
- locked  output  1  state == LOCKED

Behaviour:
- Reset: asynchronous, active-low (rst_n). While rst_n=0:
  - state=IDLE, prio_ptr=0, owner=0, burst_cnt=0
  - req_rdy=0, gen_alloc_rdy=0, locked=0, grant_id=0
- Handshakes are combinational, zero latency:
  - gen_alloc_rdy = |req_rdy.
  - Transfer to requester i when req_rdy[i]=1, which implies req_val[i]=1 and gen_alloc_val=1.
  - req_seq_num = gen_alloc_seq_num at all times.
- squash_val=1 forces req_rdy=0 and gen_alloc_rdy=0 that cycle, so no transfer occurs.
- IDLE grant: the first i with req_val[i]=1, searching cyclically from prio_ptr (prio_ptr, prio_ptr+1, ... mod p_num_reqs). At most one grant.
- LOCKED grant: only the owner can be granted, when req_val[owner]=1; all other req_rdy=0.
- State transitions, evaluated at posedge. Squash takes priority over everything:
  - squash_val=1: state<=IDLE, burst_cnt<=0; prio_ptr unchanged.
  - IDLE, transfer to g, req_lock[g]=1, p_max_burst>1: state<=LOCKED, owner<=g, burst_cnt<=1; prio_ptr unchanged.
  - IDLE, transfer to g, otherwise: prio_ptr<=(g+1) mod p_num_reqs.
  - IDLE, no transfer: hold.
  - LOCKED, req_lock[owner]=0: state<=IDLE, prio_ptr<=(owner+1) mod p_num_reqs, burst_cnt<=0. A transfer in the same cycle still completes.
  - LOCKED, transfer, burst_cnt+1==p_max_burst: same exit as above.
  - LOCKED, transfer, otherwise: burst_cnt<=burst_cnt+1.
  - LOCKED, no transfer, req_lock[owner]=1: hold. The owner may stall indefinitely; gen_alloc_val=0 is not an exit condition.
- Widths and wrap:
  - prio_ptr and owner wrap modulo p_num_reqs; non-power-of-2 p_num_reqs must be handled.
  - burst_cnt is $clog2(p_max_burst+1) bits and never exceeds p_max_burst-1 while registered.
- Fairness: after any burst or single transfer, priority passes to the next index. Every requester holding req_val is granted within p_num_reqs*p_max_burst transfers.
- gen_alloc_val=0: no grants, state and prio_ptr unchanged, locked state kept.
- Reset mid-burst: lock is dropped immediately and asynchronously.
- Outputs:
  - grant_id equals the granted index when |req_rdy=1; otherwise it equals prio_ptr in IDLE and owner in LOCKED.
  - locked reflects registered state.
- Concurrent allocation and squash in the generator need no arbiter handling beyond suppression.

Test Plan:
- Reset release, p_num_reqs=2, req_val=2'b11, gen_alloc_val=1, gen numbers 0,1,2,3 -> req_rdy alternates 01,10,01,10; grant_id 0,1,0,1; each requester sees its even/odd number.
- req_lock[0]=1 held, req_val=2'b11, p_max_burst=4 -> requester 0 granted 4 consecutive cycles (numbers 0–3), locked=1 for cycles 2–4, then requester 1 granted; prio_ptr=1 after the burst.
- LOCKED owner 0 with req_val[0]=0 for 3 cycles, req_val[1]=1 -> no grants, gen_alloc_rdy=0; drop req_lock[0] -> next cycle requester 1 granted.
- squash_val=1 during a LOCKED burst with gen_alloc_val=1 -> req_rdy=0 and gen_alloc_rdy=0 that cycle; next cycle locked=0 and the round-robin grant resumes from the unchanged prio_ptr.
- p_num_reqs=3, only req_val[2] set, then all set -> requester 2 granted, then order 0,1,2; verify the wrap from 2 to 0.
- rst_n asserted asynchronously mid-burst (between clock edges) -> req_rdy, gen_alloc_rdy and locked drop to 0 immediately; after release the first grant goes to requester 0.
